// File: rtl/inst_mem.sv
// Instruction memory with valid/ready fetch port and program-load port.
// Ports: clk, rst (async active-low), fetch_req/fetch_addr/fetch_ready,
//   inst/inst_valid response, load_en/load_addr/load_data writes.
// Optional wait states: define IMEM_WAIT_EN (latency 1+WAIT_CYCLES).
module inst_mem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_addr,
  output logic        fetch_ready,
  output logic [15:0] inst,
  output logic        inst_valid,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [15:0] load_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        accept;
  logic [15:0] mem [DEPTH] = '{default: 16'h0000};

  assign accept     = fetch_req && fetch_ready;
  assign inst_valid = (state == RESP);

  // Contents survive reset; loads are blocked while held in reset.
  always_ff @(posedge clk) begin
    if (load_en && rst)
      mem[load_addr] <= load_data;
  end

`ifdef IMEM_WAIT_EN

  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [3:0] cnt;
  logic [7:0] cap;

  assign fetch_ready = rst && (state != WAIT);

  // Read happens at the edge the counter hits zero, so loads
  // landing earlier in WAIT are returned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      inst  <= 16'h0000;
      cnt   <= 4'd0;
      cap   <= 8'h00;
    end else begin
      unique case (1'b1)
        (state == WAIT): begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            inst  <= mem[cap];
            state <= RESP;
          end
        end
        accept: begin
          if (WAIT_LD == 4'd0) begin
            inst  <= mem[fetch_addr];
            state <= RESP;
          end else begin
            cap   <= fetch_addr;
            cnt   <= WAIT_LD;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  localparam int unused_wait = WAIT_CYCLES;

  assign fetch_ready = rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      inst  <= 16'h0000;
    end else if (accept) begin
      inst  <= mem[fetch_addr];
      state <= RESP;
    end else begin
      state <= IDLE;
    end
  end

`endif

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem.
// Expected values are hand-computed; latency follows IMEM_WAIT_EN.
module tb_inst_mem;

  localparam int WC = 2;
`ifdef IMEM_WAIT_EN
  localparam int LAT = 1 + WC;
  localparam logic [15:0] SAME_EDGE = 16'hBEEF;
`else
  localparam int LAT = 1;
  localparam logic [15:0] SAME_EDGE = 16'h0F0F;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_ready;
  logic [15:0] inst;
  logic        inst_valid;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  inst_mem #(
    .DEPTH(256),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready),
    .inst(inst),
    .inst_valid(inst_valid),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Starts and ends at edge+1; ends in the response cycle.
  task automatic fetch(input logic [7:0] a,
                       input logic [15:0] exp,
                       input string tag);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(posedge clk); #1;
    fetch_req  = 1'b0;
    fetch_addr = 8'hFF;
    load_en    = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      check({tag, "_wait_rdy"}, 32'(fetch_ready), 32'd0);
      check({tag, "_wait_vld"}, 32'(inst_valid), 32'd0);
      @(posedge clk); #1;
    end
    check({tag, "_vld"}, 32'(inst_valid), 32'd1);
    check({tag, "_inst"}, 32'(inst), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 8'h00;
    load_en    = 1'b0;
    load_addr  = 8'h00;
    load_data  = 16'h0000;
    #3;
    check("rst_inst", 32'(inst), 32'h0);
    check("rst_vld", 32'(inst_valid), 32'd0);
    check("rst_rdy", 32'(fetch_ready), 32'd0);

    // load attempted while in reset must be dropped
    load_en   = 1'b1;
    load_addr = 8'h07;
    load_data = 16'hDEAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    load_en = 1'b0;
    #4;
    rst = 1'b1;
    #1;
    check("rel_rdy", 32'(fetch_ready), 32'd1);
    check("rel_vld", 32'(inst_valid), 32'd0);
    @(posedge clk); #1;

    load(8'h03, 16'hA5C3);
    fetch(8'h03, 16'hA5C3, "f03");
    @(posedge clk); #1;
    check("f03_after_vld", 32'(inst_valid), 32'd0);
    check("f03_hold", 32'(inst), 32'hA5C3);

    fetch(8'h07, 16'h0000, "rst_load_ign");
    fetch(8'h80, 16'h0000, "unloaded");

    load(8'h00, 16'h1111);
    load(8'h01, 16'h2222);
`ifndef IMEM_WAIT_EN
    fetch_req  = 1'b1;
    fetch_addr = 8'h00;
    @(posedge clk); #1;
    fetch_addr = 8'h01;
    check("b2b0_vld", 32'(inst_valid), 32'd1);
    check("b2b0_inst", 32'(inst), 32'h1111);
    check("b2b0_rdy", 32'(fetch_ready), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    check("b2b1_vld", 32'(inst_valid), 32'd1);
    check("b2b1_inst", 32'(inst), 32'h2222);
    @(posedge clk); #1;
    check("b2b_end_vld", 32'(inst_valid), 32'd0);
`else
    fetch(8'h00, 16'h1111, "seq0");
    fetch(8'h01, 16'h2222, "seq1");
    @(posedge clk); #1;
    // load to captured address during WAIT
    fetch_req  = 1'b1;
    fetch_addr = 8'h10;
    @(posedge clk); #1;
    fetch_req  = 1'b0;
    fetch_addr = 8'h11;
    load_en    = 1'b1;
    load_addr  = 8'h10;
    load_data  = 16'h7777;
    check("wld_rdy", 32'(fetch_ready), 32'd0);
    @(posedge clk); #1;
    load_en = 1'b0;
    @(posedge clk); #1;
    check("wld_vld", 32'(inst_valid), 32'd1);
    check("wld_inst", 32'(inst), 32'h7777);
`endif

    // same-edge load and fetch of one address
    load(8'h05, 16'h0F0F);
    load_en   = 1'b1;
    load_addr = 8'h05;
    load_data = 16'hBEEF;
    fetch(8'h05, SAME_EDGE, "rbw_old");
    fetch(8'h05, 16'hBEEF, "rbw_new");
    @(posedge clk); #1;

    // reset in the middle of a fetch
    fetch_req  = 1'b1;
    fetch_addr = 8'h03;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_inst", 32'(inst), 32'h0);
    check("mid_rst_vld", 32'(inst_valid), 32'd0);
    check("mid_rst_rdy", 32'(fetch_ready), 32'd0);
    #1;
    rst = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      @(posedge clk); #1;
      check("abort_vld", 32'(inst_valid), 32'd0);
    end
    fetch(8'h03, 16'hA5C3, "refetch");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem.md
INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 Parameter DEPTH, default 256; number of 16-bit instruction words held.
REQ-002 Parameter WAIT_CYCLES, default 2; wait states inserted per fetch when IMEM_WAIT_EN is defined (legal 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 fetch_req  input  1  CPU fetch request; sampled only when fetch_ready=1.
REQ-006 fetch_addr  input  8  word address of requested instruction.
REQ-007 fetch_ready  output  1  responder can accept a request this cycle.
REQ-008 inst  output  16  fetched instruction word; holds last value between responses.
REQ-009 inst_valid  output  1  inst is the response to the last accepted request, exactly one cycle per request.
REQ-010 load_en  input  1  program-load write strobe.
REQ-011 load_addr  input  8  program-load word address.
REQ-012 load_data  input  16  program-load data.

Function
REQ-013 States IDLE, WAIT, RESP; a request is accepted at the rising edge where fetch_req=1 and fetch_ready=1.
REQ-014 fetch_ready shall be 1 in IDLE and RESP, 0 in WAIT, and 0 while rst=0.
REQ-015 Accept with IMEM_WAIT_EN undefined, or WAIT_CYCLES=0: same edge registers inst <= mem[fetch_addr], next state RESP; latency 1 cycle.
REQ-016 Accept with IMEM_WAIT_EN defined and WAIT_CYCLES>0: capture fetch_addr, load wait counter with WAIT_CYCLES, next state WAIT.
REQ-017 WAIT: counter decrements each edge; on the edge where it reaches 0, inst <= mem[captured addr], next state RESP; total latency 1+WAIT_CYCLES cycles.
REQ-018 RESP: inst_valid=1 for that one cycle; a request accepted in RESP follows REQ-015/016 (back-to-back, 1 fetch/cycle when no wait states); otherwise next state IDLE.
REQ-019 inst_valid=0 in IDLE and WAIT.
REQ-020 load_en=1 writes mem[load_addr] <= load_data at the rising edge, in any state, no handshake.
REQ-021 Read and write to the same address at the same edge: inst receives the old word (read-before-write); the new word is visible from the next read.
REQ-022 Load during WAIT to the captured address before the read edge: response returns the new word.
REQ-023 fetch_addr changes while fetch_ready=0 are ignored; address is captured only at accept.
REQ-024 Memory words are 16'h0000 at time zero; unloaded words read as 16'h0000.

Reset
REQ-025 rst=0 immediately forces state IDLE, inst=16'h0000, inst_valid=0, wait counter 0, independent of clk.
REQ-026 Reset during WAIT or RESP aborts the fetch; no inst_valid is produced for it after release.
REQ-027 Memory contents are not cleared by reset; load_en is ignored while rst=0.
REQ-028 First request can be accepted at the first rising edge after rst returns to 1.

Configuration
REQ-029 Macro IMEM_WAIT_EN: defined -> WAIT state and counter compiled in, latency 1+WAIT_CYCLES; undefined -> WAIT state and counter absent, fetch_ready=1 whenever rst=1, latency fixed at 1, WAIT_CYCLES ignored.

Verification
REQ-030 rst=0 -> inst=16'h0000, inst_valid=0, fetch_ready=0; release rst -> fetch_ready=1 with no clock edge required.
REQ-031 Macro off: load 0x03=16'hA5C3, then fetch 0x03 -> inst_valid=1 one cycle after accept, inst=16'hA5C3, inst_valid=0 on the following cycle.
REQ-032 Macro off: load 0x00=16'h1111, 0x01=16'h2222; fetch 0x00 and 0x01 on consecutive edges -> inst_valid high two consecutive cycles with 1111 then 2222.
REQ-033 Macro on, WAIT_CYCLES=2: accept at edge N -> fetch_ready=0 after edges N and N+1, inst_valid=1 only in the cycle after edge N+2.
REQ-034 Macro off: mem[0x05]=16'h0F0F; at one edge load 0x05=16'hBEEF and accept fetch 0x05 -> inst=16'h0F0F; next fetch 0x05 -> 16'hBEEF.
REQ-035 Macro on: assert rst=0 mid-WAIT -> inst=16'h0000 at once, no inst_valid after release, mem[0x03] still 16'hA5C3 on refetch.
